// File: rtl/scaled_frame_buffer.sv
// Multi-buffered RGB565 frame store with upscaled, optionally mirrored readout,
// tear-free buffer swaps on frame_start_in and a colour-fill clear engine.
module scaled_frame_buffer #(
  parameter int FB_WIDTH    = 320,
  parameter int FB_HEIGHT   = 180,
  parameter int SCALE_SHIFT = 2,
  parameter int NUM_BUFFERS = 2,
  parameter int MIRROR_X    = 1,
  parameter int H_WIDTH     = 11,
  parameter int V_WIDTH     = 10,
  localparam int FB_SIZE    = $clog2(FB_WIDTH * FB_HEIGHT)
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic [H_WIDTH-1:0] hcount_in,
  input  logic [V_WIDTH-1:0] vcount_in,
  input  logic               frame_start_in,
  output logic [7:0]         red_out,
  output logic [7:0]         green_out,
  output logic [7:0]         blue_out,
  input  logic [FB_SIZE-1:0] write_addr_in,
  input  logic [15:0]        write_data_in,
  input  logic               write_valid_in,
  input  logic               swap_in,
  input  logic               clear_in,
  input  logic [15:0]        clear_color_in,
  output logic               write_busy_out,
  output logic [1:0]         disp_buf_out
);

  // state   | meaning
  // S_IDLE  | accepting writes, swaps and clear requests
  // S_CLEAR | filling the write buffer with the clear colour, one word per cycle

  localparam int NPIX = FB_WIDTH * FB_HEIGHT;

  typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 w_clr_active;
  logic [FB_SIZE-1:0]   r_clr_addr;
  logic [15:0]          r_clr_color;
  logic                 w_clr_last;

  logic [1:0]           r_disp, r_wr, r_ready;
  logic                 r_ready_valid, r_pending;
  logic [1:0]           w_disp_nxt, w_wr_nxt, w_ready_nxt;
  logic                 w_ready_valid_nxt, w_pending_nxt;

  logic                 w_busy, w_swap_ok, w_clr_ok, w_wr_ok;
  logic                 w_ram_we;
  logic [FB_SIZE-1:0]   w_ram_addr;
  logic [15:0]          w_ram_data;

  logic [H_WIDTH-1:0]   w_x;
  logic [V_WIDTH-1:0]   w_y;
  logic                 w_in_range;
  logic [31:0]          w_xm;
  logic [FB_SIZE-1:0]   w_rd_addr;
  logic [NUM_BUFFERS-1:0][15:0] w_rd_all;
  logic [15:0]          w_sel;

  logic [1:0]           r_disp_d1;
  logic                 r_in_range_d1;
  logic [7:0]           r_red, r_green, r_blue;

  assign w_busy     = r_pending | w_clr_active;
  assign w_swap_ok  = swap_in & ~w_busy;
  assign w_clr_ok   = clear_in & ~w_busy;
  assign w_wr_ok    = write_valid_in & ~w_busy & (32'(write_addr_in) < 32'(NPIX));
  assign w_clr_last = (32'(r_clr_addr) == 32'(NPIX - 1));

  always_ff @(posedge clk_in) begin
    if (!rst_in) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_clr_ok)   w_state_nxt = S_CLEAR;
      S_CLEAR: if (w_clr_last) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_clr_active = (r_state == S_CLEAR);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_clr_addr  <= '0;
      r_clr_color <= '0;
    end else if (w_clr_ok) begin
      r_clr_addr  <= '0;
      r_clr_color <= clear_color_in;
    end else if (w_clr_active) begin
      r_clr_addr  <= r_clr_addr + 1'b1;
    end
  end

  always_comb begin
    w_disp_nxt        = r_disp;
    w_wr_nxt          = r_wr;
    w_ready_nxt       = r_ready;
    w_ready_valid_nxt = r_ready_valid;
    w_pending_nxt     = r_pending;
    if (NUM_BUFFERS == 3) begin
      if (w_swap_ok) begin
        w_ready_nxt       = r_wr;
        w_wr_nxt          = r_ready;
        w_ready_valid_nxt = 1'b1;
      end
      // swap lands first, so a same-cycle commit shows the frame just finished
      if (frame_start_in && w_ready_valid_nxt) begin
        w_disp_nxt        = w_ready_nxt;
        w_ready_nxt       = r_disp;
        w_ready_valid_nxt = 1'b0;
      end
    end else begin
      if (w_swap_ok) w_pending_nxt = 1'b1;
      if (frame_start_in && w_pending_nxt) begin
        w_disp_nxt    = r_wr;
        w_wr_nxt      = r_disp;
        w_pending_nxt = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_disp        <= 2'd0;
      r_wr          <= 2'd1;
      r_ready       <= 2'd2;
      r_ready_valid <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      r_disp        <= w_disp_nxt;
      r_wr          <= w_wr_nxt;
      r_ready       <= w_ready_nxt;
      r_ready_valid <= w_ready_valid_nxt;
      r_pending     <= w_pending_nxt;
    end
  end

  assign w_ram_we   = rst_in & (w_clr_active | w_wr_ok);
  assign w_ram_addr = w_clr_active ? r_clr_addr  : write_addr_in;
  assign w_ram_data = w_clr_active ? r_clr_color : write_data_in;

  assign w_x        = hcount_in >> SCALE_SHIFT;
  assign w_y        = vcount_in >> SCALE_SHIFT;
  assign w_in_range = (32'(w_x) < 32'(FB_WIDTH)) && (32'(w_y) < 32'(FB_HEIGHT));
  assign w_xm       = (MIRROR_X != 0) ? (32'(FB_WIDTH - 1) - 32'(w_x)) : 32'(w_x);
  // out-of-range coordinates park on address 0; the pixel is blanked later
  assign w_rd_addr  = w_in_range ? FB_SIZE'(w_xm + 32'(w_y) * 32'(FB_WIDTH)) : '0;

  for (genvar b = 0; b < NUM_BUFFERS; b++) begin : g_buf
    logic [15:0] r_mem [NPIX];
    logic [15:0] r_q;
    always_ff @(posedge clk_in) begin
      if (w_ram_we && (r_wr == 2'(b))) r_mem[w_ram_addr] <= w_ram_data;
      r_q <= r_mem[w_rd_addr];
    end
    assign w_rd_all[b] = r_q;
  end

  always_comb begin
    w_sel = '0;
    for (int b = 0; b < NUM_BUFFERS; b++) begin
      if (r_disp_d1 == 2'(b)) w_sel = w_rd_all[b];
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_disp_d1     <= 2'd0;
      r_in_range_d1 <= 1'b0;
      r_red         <= '0;
      r_green       <= '0;
      r_blue        <= '0;
    end else begin
      r_disp_d1     <= r_disp;
      r_in_range_d1 <= w_in_range;
      r_red         <= r_in_range_d1 ? {w_sel[15:11], w_sel[15:13]} : 8'd0;
      r_green       <= r_in_range_d1 ? {w_sel[10:5],  w_sel[10:9]}  : 8'd0;
      r_blue        <= r_in_range_d1 ? {w_sel[4:0],   w_sel[4:2]}   : 8'd0;
    end
  end

  assign red_out        = r_red;
  assign green_out      = r_green;
  assign blue_out       = r_blue;
  assign write_busy_out = w_busy;
  assign disp_buf_out   = r_disp;

endmodule

// File: tb/tb_scaled_frame_buffer.sv
// Randomized bench for scaled_frame_buffer: a double-buffered full-size instance
// and a small triple-buffered instance, both checked against a behavioural model.
module tb_scaled_frame_buffer;

  localparam int DW = 320, DH = 180, DS = 2, DN = DW * DH;
  localparam int TW = 16,  TH = 8,   TS = 1, TN = TW * TH;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [10:0] d_h, t_h;
  logic [9:0]  d_v, t_v;
  logic        d_fs, d_wv, d_swap, d_clr, t_fs, t_wv, t_swap, t_clr;
  logic [15:0] d_wa;
  logic [6:0]  t_wa;
  logic [15:0] d_wd, d_cc, t_wd, t_cc;
  logic [7:0]  d_r, d_g, d_b, t_r, t_g, t_b;
  logic        d_busy, t_busy;
  logic [1:0]  d_disp, t_disp;

  scaled_frame_buffer u_dbl (
    .clk_in(clk), .rst_in(rst), .hcount_in(d_h), .vcount_in(d_v),
    .frame_start_in(d_fs), .red_out(d_r), .green_out(d_g), .blue_out(d_b),
    .write_addr_in(d_wa), .write_data_in(d_wd), .write_valid_in(d_wv),
    .swap_in(d_swap), .clear_in(d_clr), .clear_color_in(d_cc),
    .write_busy_out(d_busy), .disp_buf_out(d_disp)
  );

  scaled_frame_buffer #(
    .FB_WIDTH(TW), .FB_HEIGHT(TH), .SCALE_SHIFT(TS), .NUM_BUFFERS(3), .MIRROR_X(0),
    .H_WIDTH(11), .V_WIDTH(10)
  ) u_tri (
    .clk_in(clk), .rst_in(rst), .hcount_in(t_h), .vcount_in(t_v),
    .frame_start_in(t_fs), .red_out(t_r), .green_out(t_g), .blue_out(t_b),
    .write_addr_in(t_wa), .write_data_in(t_wd), .write_valid_in(t_wv),
    .swap_in(t_swap), .clear_in(t_clr), .clear_color_in(t_cc),
    .write_busy_out(t_busy), .disp_buf_out(t_disp)
  );

  int n_total = 0;
  int n_bad   = 0;
  bit rand_rd = 1'b1;

  // model memories with "contents known" flags, since the RAMs are not reset
  logic [15:0] dm    [2][DN];
  bit          dm_ok [2][DN];
  logic [15:0] tm    [3][TN];
  bit          tm_ok [3][TN];

  int          md_disp, md_wr, md_left, md_caddr;
  bit          md_pend;
  logic [15:0] md_col;
  logic [24:0] md_p1, md_out;

  int          mt_disp, mt_wr, mt_ready, mt_left, mt_caddr;
  bit          mt_rv;
  logic [15:0] mt_col;
  logic [24:0] mt_p1, mt_out;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [23:0] expand(input logic [15:0] c);
    int r, g, b;
    r = int'(c[15:11]);
    g = int'(c[10:5]);
    b = int'(c[4:0]);
    return {8'(r * 8 + r / 4), 8'(g * 4 + g / 16), 8'(b * 8 + b / 4)};
  endfunction

  // bit 24 set = expected pixel is known
  function automatic logic [24:0] d_pix();
    int x, y, a;
    x = int'(d_h) / (1 << DS);
    y = int'(d_v) / (1 << DS);
    if (x >= DW || y >= DH) return 25'h1000000;
    a = (DW - 1 - x) + DW * y;
    if (!dm_ok[md_disp][a]) return 25'h0;
    return {1'b1, expand(dm[md_disp][a])};
  endfunction

  function automatic logic [24:0] t_pix();
    int x, y, a;
    x = int'(t_h) / (1 << TS);
    y = int'(t_v) / (1 << TS);
    if (x >= TW || y >= TH) return 25'h1000000;
    a = x + TW * y;
    if (!tm_ok[mt_disp][a]) return 25'h0;
    return {1'b1, expand(tm[mt_disp][a])};
  endfunction

  task automatic model_step();
    logic [24:0] cur;
    bit busy;
    int tmp, nd, nr;
    if (!rst) begin
      md_disp = 0; md_wr = 1; md_pend = 0; md_left = 0; md_caddr = 0;
      md_p1 = 25'h1000000; md_out = 25'h1000000;
      mt_disp = 0; mt_wr = 1; mt_ready = 2; mt_rv = 0; mt_left = 0; mt_caddr = 0;
      mt_p1 = 25'h1000000; mt_out = 25'h1000000;
      return;
    end
    cur = d_pix(); md_out = md_p1; md_p1 = cur;
    busy = md_pend || (md_left > 0);
    if (md_left > 0) begin
      dm[md_wr][md_caddr] = md_col; dm_ok[md_wr][md_caddr] = 1'b1;
      md_caddr++; md_left--;
    end else if (d_wv && !busy && int'(d_wa) < DN) begin
      dm[md_wr][int'(d_wa)] = d_wd; dm_ok[md_wr][int'(d_wa)] = 1'b1;
    end
    if (!busy && d_clr) begin md_left = DN; md_caddr = 0; md_col = d_cc; end
    if (!busy && d_swap) md_pend = 1'b1;
    if (d_fs && md_pend) begin tmp = md_disp; md_disp = md_wr; md_wr = tmp; md_pend = 1'b0; end

    cur = t_pix(); mt_out = mt_p1; mt_p1 = cur;
    busy = (mt_left > 0);
    if (mt_left > 0) begin
      tm[mt_wr][mt_caddr] = mt_col; tm_ok[mt_wr][mt_caddr] = 1'b1;
      mt_caddr++; mt_left--;
    end else if (t_wv && int'(t_wa) < TN) begin
      tm[mt_wr][int'(t_wa)] = t_wd; tm_ok[mt_wr][int'(t_wa)] = 1'b1;
    end
    if (!busy && t_clr) begin mt_left = TN; mt_caddr = 0; mt_col = t_cc; end
    if (!busy && t_swap && t_fs) begin
      // finished frame goes straight to display; old display becomes ready;
      // writer gets whichever buffer is left over
      nd = mt_wr; nr = mt_disp;
      mt_wr = 3 - nd - nr; mt_disp = nd; mt_ready = nr; mt_rv = 1'b0;
    end else if (!busy && t_swap) begin
      tmp = mt_ready; mt_ready = mt_wr; mt_wr = tmp; mt_rv = 1'b1;
    end else if (t_fs && mt_rv) begin
      tmp = mt_disp; mt_disp = mt_ready; mt_ready = tmp; mt_rv = 1'b0;
    end
  endtask

  task automatic tick();
    if (rand_rd) begin
      d_h = 11'($urandom_range(0, 1400)); d_v = 10'($urandom_range(0, 800));
      t_h = 11'($urandom_range(0, 40));   t_v = 10'($urandom_range(0, 20));
    end
    model_step();
    @(posedge clk);
    #1;
    if (md_out[24]) check("d_pix", 32'({d_r, d_g, d_b}), 32'(md_out[23:0]));
    check("d_busy", 32'(d_busy), 32'(md_pend || md_left > 0));
    check("d_disp", 32'(d_disp), 32'(md_disp));
    if (mt_out[24]) check("t_pix", 32'({t_r, t_g, t_b}), 32'(mt_out[23:0]));
    check("t_busy", 32'(t_busy), 32'(mt_left > 0));
    check("t_disp", 32'(t_disp), 32'(mt_disp));
  endtask

  task automatic t_clear(input logic [15:0] c);
    t_clr = 1'b1; t_cc = c; tick(); t_clr = 1'b0;
    repeat (TN) tick();
  endtask

  task automatic t_fill();
    repeat (20) begin
      t_wv = 1'b1; t_wa = 7'($urandom_range(TN / 2, TN - 1)); t_wd = 16'($urandom); tick();
    end
    t_wv = 1'b0;
  endtask

  task automatic t_read0(input string tag, input logic [15:0] c);
    rand_rd = 1'b0; t_h = '0; t_v = '0;
    repeat (3) tick();
    check(tag, 32'({t_r, t_g, t_b}), 32'(expand(c)));
    rand_rd = 1'b1;
  endtask

  initial begin
    int cnt;
    {d_h, d_v, d_fs, d_wv, d_swap, d_clr, d_wa, d_wd, d_cc} = '0;
    {t_h, t_v, t_fs, t_wv, t_swap, t_clr, t_wa, t_wd, t_cc} = '0;
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // double mode: clear write buffer green, with ignored traffic while busy
    d_clr = 1'b1; d_cc = 16'h07E0; tick(); d_clr = 1'b0;
    cnt = d_busy ? 1 : 0;
    for (int i = 0; i <= DN; i++) begin
      d_wv = ($urandom_range(0, 99) == 0);
      d_wa = 16'($urandom_range(0, DN + 50)); d_wd = 16'($urandom);
      d_swap = (i == 100);
      d_clr = (i == 200); d_cc = 16'hF800;
      tick();
      cnt += d_busy ? 1 : 0;
    end
    {d_wv, d_swap, d_clr} = '0;
    check("d_clr_len", 32'(cnt), 32'(DN));

    d_swap = 1'b1; tick(); d_swap = 1'b0;
    d_wv = 1'b1; d_wa = 16'd7; d_wd = 16'hF800; tick(); d_wv = 1'b0;
    repeat (2) tick();
    d_fs = 1'b1; tick(); d_fs = 1'b0;
    check("d_disp_swap1", 32'(d_disp), 32'd1);
    rand_rd = 1'b0; d_h = 11'((DW - 1 - 7) * 4); d_v = '0;
    repeat (3) tick();
    check("d_drop_wr", 32'({d_r, d_g, d_b}), 32'h00FF00);
    rand_rd = 1'b1;
    repeat (1500) tick();

    d_wv = 1'b1; d_wa = 16'd0; d_wd = 16'hF800; tick();
    d_wa = 16'(DN); d_wd = 16'h001F; tick();
    repeat (50) begin d_wa = 16'($urandom_range(1, DN - 1)); d_wd = 16'($urandom); tick(); end
    d_wv = 1'b0;
    d_swap = 1'b1; tick(); d_swap = 1'b0;
    tick();
    d_fs = 1'b1; tick(); d_fs = 1'b0;
    check("d_disp_swap2", 32'(d_disp), 32'd0);
    rand_rd = 1'b0; d_h = 11'((DW - 1) * 4); d_v = '0;
    repeat (3) tick();
    check("d_red_px", 32'({d_r, d_g, d_b}), 32'hFF0000);
    d_h = 11'd1280; d_v = '0; repeat (3) tick();
    check("d_oor_h", 32'({d_r, d_g, d_b}), 32'h0);
    d_h = '0; d_v = 10'd720; repeat (3) tick();
    check("d_oor_v", 32'({d_r, d_g, d_b}), 32'h0);
    rand_rd = 1'b1;

    repeat (2000) begin
      d_wv = 1'($urandom_range(0, 1));
      d_wa = 16'($urandom_range(0, DN + 20)); d_wd = 16'($urandom);
      d_swap = ($urandom_range(0, 49) == 0);
      d_fs = ($urandom_range(0, 39) == 0);
      tick();
    end
    {d_wv, d_swap, d_fs} = '0;

    // triple mode: three completed frames, one commit shows the last
    t_clear(16'h1111); t_fill(); t_swap = 1'b1; tick(); t_swap = 1'b0;
    t_clear(16'h2222); t_fill(); t_swap = 1'b1; tick(); t_swap = 1'b0;
    t_clear(16'h3333); t_fill(); t_swap = 1'b1; tick(); t_swap = 1'b0;
    t_fs = 1'b1; tick(); t_fs = 1'b0;
    check("t_last_disp", 32'(t_disp), 32'd1);
    t_read0("t_last_px", 16'h3333);

    t_clear(16'h4444);
    t_swap = 1'b1; t_fs = 1'b1; tick(); t_swap = 1'b0; t_fs = 1'b0;
    check("t_same_disp", 32'(t_disp), 32'd2);
    t_read0("t_same_px", 16'h4444);

    t_clear(16'h5555);
    t_swap = 1'b1; tick(); t_swap = 1'b0;
    t_fs = 1'b1; tick(); t_fs = 1'b0;
    check("t_free_disp", 32'(t_disp), 32'd0);
    t_read0("t_free_px", 16'h5555);

    repeat (3000) begin
      t_wv = 1'($urandom_range(0, 1));
      t_wa = 7'($urandom_range(0, TN - 1)); t_wd = 16'($urandom);
      t_clr = ($urandom_range(0, 199) == 0); t_cc = 16'($urandom);
      t_swap = !t_clr && ($urandom_range(0, 29) == 0);
      t_fs = ($urandom_range(0, 24) == 0);
      tick();
    end
    {t_wv, t_clr, t_swap, t_fs} = '0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
